// File: rtl/lza_pipe.sv
// Pipelined leading-zero anticipator: indicator vector in S1, priority-encoded shift count in S2.
// Define LZA_CORRECT_EN to add the sum check that applies the one-bit correction (out_corr).
module lza_pipe #(
   parameter int W  = 27,
   parameter int CW = $clog2(W)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_a,
   input  logic [W-1:0]  in_b,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] out_lzc,
   output logic          out_corr
);

   logic          adv1, adv2;
   logic          s1_v, s2_v;
   logic [W-1:0]  e_n;
   logic [W-1:0]  s1_e;
   logic [CW-1:0] p;
   logic [CW-1:0] lzc_p;
   logic [CW-1:0] lzc_n;
   logic [CW-1:0] s2_lzc;

   assign adv2     = !s2_v || out_ready;
   assign adv1     = !s1_v || adv2;
   assign in_ready = adv1;

   // Bit 0 is forced high so the encoder always finds a set bit.
   always_comb begin
      e_n    = '0;
      e_n[0] = 1'b1;
      for (int i = 1; i < W; i++) begin
         e_n[i] = ~(in_a[i] ^ in_b[i]) & (in_a[i-1] | in_b[i-1]);
      end
   end

   always_comb begin
      p = '0;
      for (int i = 0; i < W; i++) begin
         if (s1_e[i]) p = CW'(i);
      end
   end

   assign lzc_p = CW'(W - 1) - p;

`ifdef LZA_CORRECT_EN
   logic [W-1:0] s1_s;
   logic         corr_n;
   logic         s2_corr;

   // Sum bit at the predicted leading position is p itself (W-1-lzc_p).
   always_comb begin
      corr_n = 1'b0;
      lzc_n  = lzc_p;
      if (!s1_s[p] && (lzc_p != CW'(W - 1))) begin
         corr_n = 1'b1;
         lzc_n  = lzc_p + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (adv1 && in_valid) s1_s <= in_a + in_b;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_corr <= 1'b0;
      end else if (adv2 && s1_v) begin
         s2_corr <= corr_n;
      end
   end

   assign out_corr = s2_corr;
`else
   assign lzc_n    = lzc_p;
   assign out_corr = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (adv1 && in_valid) s1_e <= e_n;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v   <= 1'b0;
         s2_v   <= 1'b0;
         s2_lzc <= '0;
      end else begin
         if (adv1) s1_v <= in_valid;
         if (adv2) begin
            s2_v <= s1_v;
            if (s1_v) s2_lzc <= lzc_n;
         end
      end
   end

   assign out_valid = s2_v;
   assign out_lzc   = s2_lzc;

endmodule

// File: doc/lza_pipe.md
Name: lza_pipe

Overview:
- Parametrised, pipelined leading-zero anticipator for the FPU-GP add/sub datapath.
- Takes aligned mantissa operands A and B and builds the anticipation indicator vector E.
- Priority-encodes E into a normalisation shift count, with valid/ready flow control.
- Successor of the fixed 27-bit combinational indicator: the width is generic, it is registered, it applies backpressure, and an optional one-bit correction is available.

Parameters:
- W, 27, operand and indicator width; legal range is 4 or more.
- CW, $clog2(W), width of the shift count (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  A/B pair is valid this cycle.
- in_ready  out  1  block accepts the pair this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_lzc  out  CW  leading-zero count / normalisation shift, range 0..W-1.
- out_corr  out  1  correction applied (LZA_CORRECT_EN only; otherwise constant 0).

Behaviour:
- Indicator:
  - E[0] = 1.
  - For i = 1..W-1: E[i] = (A[i] XNOR B[i]) AND (A[i-1] OR B[i-1]).
- Count:
  - p = index of the highest set bit of E.
  - Predicted count lzc_p = W-1-p.
  - E[0] = 1 guarantees a set bit, so lzc_p is always in 0..W-1.
- Pipeline: two register stages.
  - S1 holds E (plus the sum when the feature is enabled) and s1_v.
  - S2 holds lzc/corr and s2_v.
  - Latency is exactly 2 cycles from acceptance (in_valid & in_ready) to out_valid, with no stalls.
  - Throughput is 1 result per cycle.
- Handshake:
  - adv2 = !s2_v | out_ready.
  - adv1 = !s1_v | adv2.
  - in_ready = adv1; it is combinational and has no dependence on in_valid.
  - S2 loads S1 contents when adv2; s2_v <= s1_v.
  - S1 loads inputs when adv1; s1_v <= in_valid.
- Stall: while out_valid & !out_ready, out_lzc and out_corr hold stable and no result is dropped or duplicated.
- Full condition:
  - Both stages valid and out_ready = 0 gives in_ready = 0.
  - If out_ready rises in the same cycle, in_ready = 1 that cycle (pass-through).
- Ordering: strictly in-order; there is no reordering or bypass.
- Reset:
  - rst_n = 0 at an edge clears s1_v and s2_v; this includes reset mid-operation, where in-flight data is discarded.
  - out_valid = 0, out_lzc = 0 and out_corr = 0 after reset.
  - in_ready is 1 after reset.
  - Data registers need not be cleared except those driving outputs.
- Inputs are ignored when in_valid = 0 (no S1 data update is required, but s1_v must become 0 when adv1).

Optional Feature:
- Macro: LZA_CORRECT_EN.
- When defined:
  - S1 also registers S = (in_a + in_b) mod 2^W.
  - S2 checks bit S[W-1-lzc_p]. If that bit is 0 and lzc_p < W-1, it outputs out_lzc = lzc_p+1 and out_corr = 1.
  - Otherwise it outputs out_lzc = lzc_p and out_corr = 0.
  - Latency is unchanged.
- When undefined:
  - No adder is present.
  - out_lzc = lzc_p and out_corr is tied to 0.

Test Plan:
- Reset, then A=0x0000001, B=0x0000001, W=27 -> E highest bit 1, out_lzc=25, out_corr=0, out_valid exactly 2 cycles after acceptance.
- A=0x2000000, B=0x2000000 -> out_lzc=0, out_corr=0.
- A=0x0000100, B=0 -> predicted p=9, out_lzc=17; with LZA_CORRECT_EN: out_lzc=18, out_corr=1.
- A=0, B=0 -> out_lzc=26; with LZA_CORRECT_EN: out_corr=0 (lzc_p = W-1 boundary).
- Backpressure:
  - Hold out_ready=0 and drive three back-to-back valid inputs.
  - in_ready must drop after two are accepted, and out_lzc must be stable while stalled.
  - Raise out_ready: results emerge in order, one per cycle, and the third input is accepted in the release cycle.
- Reset mid-operation: assert rst_n=0 with both stages valid -> out_valid=0 and in_ready=1 on the next edge; no stale result appears after reset is released.
